// File: rtl/pipeline_register.sv
// Single-stage valid/ready register slice with a skid register; every output is a flop.
// Define PIPELINE_REG_STALL_CNT_EN to add a saturating stall_count output.
module pipeline_register #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
`ifdef PIPELINE_REG_STALL_CNT_EN
  ,
  output logic [15:0]           stall_count
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] skid;

  // out_data doubles as the main register; in_ready/out_valid track the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_data  <= '0;
      skid      <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_valid) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (in_valid && out_ready) begin
            out_data <= in_data;
          end else if (in_valid) begin
            skid     <= in_data;
            in_ready <= 1'b0;
            state    <= FULL;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
        FULL: begin
          if (out_ready) begin
            out_data <= skid;
            in_ready <= 1'b1;
            state    <= BUSY;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= EMPTY;
        end
      endcase
    end
  end

`ifdef PIPELINE_REG_STALL_CNT_EN
  // Counts cycles where a beat is presented but not taken; saturates at all ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
    end else if (out_valid && !out_ready && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_register.sv
// Bench for pipeline_register: a two-entry ordered queue model checked every cycle,
// plus directed literal checks; stall counter checks run when PIPELINE_REG_STALL_CNT_EN is defined.
module tb_pipeline_register;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
`ifdef PIPELINE_REG_STALL_CNT_EN
  logic [15:0] stall_count;
  int          stall_exp = 0;
`endif

  int tests = 0;
  int fails = 0;
  bit checking = 1'b0;
  logic [31:0] q[$];

  pipeline_register #(.DATA_WIDTH(32)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data)
`ifdef PIPELINE_REG_STALL_CNT_EN
    ,
    .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference: an in-order store of at most two beats, updated on each edge.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
`ifdef PIPELINE_REG_STALL_CNT_EN
      stall_exp = 0;
`endif
    end else begin
      automatic int  n      = q.size();
      automatic bit  in_acc = in_valid && (n < 2);
      automatic bit  out_acc = out_ready && (n > 0);
`ifdef PIPELINE_REG_STALL_CNT_EN
      if (n > 0 && !out_ready && stall_exp < 65535) stall_exp++;
`endif
      if (out_acc) void'(q.pop_front());
      if (in_acc) q.push_back(in_data);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checking) begin
      chk("model_out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("model_in_ready", 32'(in_ready), 32'(q.size() < 2));
      if (q.size() != 0) chk("model_out_data", out_data, q[0]);
`ifdef PIPELINE_REG_STALL_CNT_EN
      chk("model_stall_count", 32'(stall_count), 32'(stall_exp));
`endif
    end
  end

  task automatic cyc(input logic iv, input logic [31:0] d, input logic ordy);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    cyc(1'b1, 32'hDEADBEEF, 1'b1);
    cyc(1'b1, 32'hDEADBEEF, 1'b1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_data", out_data, 32'd0);
    checking = 1'b1;
    rst = 1'b0;

    // single beat
    cyc(1'b1, 32'hA5A5A5A5, 1'b1);
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_data", out_data, 32'hA5A5A5A5);
    cyc(1'b0, 32'd0, 1'b1);
    chk("single_drain", 32'(out_valid), 32'd0);

    // streaming 1..8 with one cycle latency
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 32'(i), 1'b1);
      chk("stream_data", out_data, 32'(i));
      chk("stream_in_ready", 32'(in_ready), 32'd1);
    end
    cyc(1'b0, 32'd0, 1'b1);
    chk("stream_drain", 32'(out_valid), 32'd0);

    // backpressure into the skid register
    cyc(1'b1, 32'hA5A5A5A5, 1'b0);
    cyc(1'b1, 32'h12345678, 1'b0);
    chk("bp_full_in_ready", 32'(in_ready), 32'd0);
    chk("bp_hold_data", out_data, 32'hA5A5A5A5);
    cyc(1'b1, 32'h00000099, 1'b0);
    chk("bp_still_full", 32'(in_ready), 32'd0);
    chk("bp_still_hold", out_data, 32'hA5A5A5A5);
    cyc(1'b0, 32'd0, 1'b1);
    chk("bp_release_data", out_data, 32'h12345678);
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    cyc(1'b0, 32'd0, 1'b1);
    chk("bp_drained", 32'(out_valid), 32'd0);

    // reset while full
    cyc(1'b1, 32'h0000000A, 1'b0);
    cyc(1'b1, 32'h0000000B, 1'b0);
    chk("rmid_full", 32'(in_ready), 32'd0);
    rst = 1'b1;
    cyc(1'b1, 32'h0000000C, 1'b1);
    rst = 1'b0;
    chk("rmid_out_valid", 32'(out_valid), 32'd0);
    chk("rmid_in_ready", 32'(in_ready), 32'd1);
    chk("rmid_out_data", out_data, 32'd0);
    cyc(1'b0, 32'd0, 1'b1);
    chk("rmid_no_old_beat", 32'(out_valid), 32'd0);

    // randomized traffic in phases of varying pressure
    for (int p = 0; p < 8; p++) begin
      automatic int vin  = 1 + (p % 4);
      automatic int vout = 1 + ((p * 3) % 4);
      for (int c = 0; c < 300; c++) begin
        cyc(1'(($urandom % 4) < vin), $urandom, 1'(($urandom % 4) < vout));
      end
    end
    for (int c = 0; c < 4; c++) cyc(1'b0, 32'd0, 1'b1);
    chk("random_drained", 32'(out_valid), 32'd0);

`ifdef PIPELINE_REG_STALL_CNT_EN
    rst = 1'b1;
    cyc(1'b0, 32'd0, 1'b0);
    rst = 1'b0;
    chk("stall_reset", 32'(stall_count), 32'd0);
    cyc(1'b1, 32'h00000055, 1'b0);
    for (int c = 0; c < 5; c++) cyc(1'b0, 32'd0, 1'b0);
    chk("stall_five", 32'(stall_count), 32'd5);
    for (int c = 0; c < 70000; c++) cyc(1'b0, 32'd0, 1'b0);
    chk("stall_saturate", 32'(stall_count), 32'h0000FFFF);
    cyc(1'b0, 32'd0, 1'b1);
`endif

    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipeline_register.md
# pipeline_register

Single-stage, full-throughput valid/ready pipeline register (skid buffer) for a 32-bit datapath by default. It inserts one cycle of latency between an upstream producer and a downstream consumer and registers every output, including `in_ready`, so it breaks all combinational timing paths in both directions. It is used as a generic register slice wherever a streaming interface crosses a timing-critical boundary.

## Interface
- `DATA_WIDTH`, default 32: payload width in bits.
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: upstream has data on `in_data`.
- `in_ready` output 1: register can accept data this cycle.
- `in_data` input DATA_WIDTH: upstream payload.
- `out_valid` output 1: `out_data` holds a valid beat.
- `out_ready` input 1: downstream accepts this cycle.
- `out_data` output DATA_WIDTH: downstream payload.
- `stall_count` output 16: present only with `PIPELINE_REG_STALL_CNT_EN` (see Configuration).

## Operation
- Input transfer: `in_valid && in_ready` at a rising edge. Output transfer: `out_valid && out_ready` at a rising edge.
- Storage: a main register (drives `out_data`) and a skid register. FSM states:
  - EMPTY: `out_valid`=0, `in_ready`=1.
  - BUSY: main full, skid empty; `out_valid`=1, `in_ready`=1.
  - FULL: both full; `out_valid`=1, `in_ready`=0.
- Transitions:
  - EMPTY + input transfer -> BUSY; main <= `in_data`.
  - BUSY + input transfer + output transfer -> BUSY; main <= `in_data`.
  - BUSY + input transfer, no output transfer -> FULL; skid <= `in_data`.
  - BUSY + output transfer only -> EMPTY.
  - FULL + output transfer -> BUSY; main <= skid.
  - Otherwise hold state and data.
- `in_valid` is ignored in FULL. `out_ready` is ignored in EMPTY.
- Beats are delivered in order. None are dropped or duplicated.
- `out_data` is stable while `out_valid`=1 and `out_ready`=0.
- Data is never combined or modified. Width is passed through unchanged.

## Timing
- All outputs come from flops. There is no combinational path from any input to any output.
- Latency: a beat accepted at edge N appears on `out_data` with `out_valid`=1 after edge N, i.e. it is transferable at edge N+1 at the earliest.
- Throughput: one beat per cycle when `out_ready` is held at 1.
- Backpressure: after `out_ready` drops, at most one further beat is accepted (into skid). `in_ready` deasserts the cycle after FULL is entered.
- Release: one cycle after `out_ready` returns to 1, the skid beat moves to main and `in_ready` reasserts.
- Reset (`rst` sampled high at an edge, including mid-transfer): state returns to EMPTY. Values after reset:
  - `out_valid`=0
  - `in_ready`=1
  - `out_data`=0
  - skid contents=0
  - `stall_count`=0
- Any in-flight beats are discarded on reset. Handshakes are not evaluated while `rst`=1.

## Configuration
- `PIPELINE_REG_STALL_CNT_EN` defined: adds the `stall_count` port.
  - 16-bit saturating counter, incremented each cycle with `out_valid`=1 and `out_ready`=0.
  - Holds at 16'hFFFF once saturated.
  - Cleared only by reset.
- `PIPELINE_REG_STALL_CNT_EN` undefined: no port and no counter logic. Handshake behaviour is identical in both builds.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with `in_valid`=1 -> `out_valid`=0, `in_ready`=1, `out_data`=0. No beat is captured.
- Single beat: `in_valid`=1 for one cycle, `in_data`=32'hA5A5A5A5, `out_ready`=1 -> next cycle `out_valid`=1, `out_data`=32'hA5A5A5A5. Then `out_valid`=0.
- Streaming: 8 consecutive beats 1..8 with `out_ready`=1 -> 8 outputs 1..8 on consecutive cycles, 1-cycle latency, `in_ready` never low.
- Backpressure: stream 32'hA5A5A5A5 then 32'h12345678 with `out_ready`=0 for 3 cycles ->
  - `out_data` holds 32'hA5A5A5A5.
  - Skid captures 32'h12345678.
  - `in_ready`=0 while FULL.
  - On `out_ready`=1, A5A5A5A5 then 12345678 are delivered, in order, with no loss.
- Reset mid-operation: assert `rst` while FULL -> next cycle EMPTY, `out_valid`=0, `in_ready`=1. Old beats never appear.
- Stall counter (macro defined): `out_valid`=1, `out_ready`=0 for 5 cycles -> `stall_count`=5. Forcing 70000 stall cycles -> `stall_count`=16'hFFFF.
